// File: rtl/ref_window_loader.sv
// ref_window_loader: gathers WIN_DIM reference rows from a valid/ready row
// stream into one flat WIN_DIM x WIN_DIM pixel window. The window is then
// offered to the subpixel interpolator on a valid/ready window port.
// Build option WIN_DBUF_EN: ping-pong banks A/B so that one bank fills while
// the other is presented. Without it, a single bank alternates between
// filling and presenting.
module ref_window_loader #(
  parameter  int PIX_W   = 8,
  parameter  int WIN_DIM = 15,
  localparam int ROW_W   = PIX_W * WIN_DIM,
  localparam int WIN_W   = ROW_W * WIN_DIM
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic             row_valid,
  input  logic             row_sof,
  input  logic [ROW_W-1:0] row_data,
  output logic             row_ready,
  output logic             win_valid,
  input  logic             win_ready,
  output logic [WIN_W-1:0] win_data,
  output logic [3:0]       rows_loaded,
  output logic             sync_err
);

  localparam logic [3:0] LAST_ROW = 4'(WIN_DIM - 1);
  localparam logic [3:0] FULL_CNT = 4'(WIN_DIM);

  logic       row_hs;
  logic       win_hs;
  logic       restart;
  logic [3:0] wr_idx;
  logic [3:0] count_q, count_d;
  logic       sync_err_q, sync_err_d;

  // A start-of-frame on a non-empty bank abandons the partial rows and
  // restarts the window with this row as row 0.
  assign row_hs      = row_valid & row_ready;
  assign win_hs      = win_valid & win_ready;
  assign restart     = row_hs & row_sof & (count_q != 4'd0);
  assign wr_idx      = restart ? 4'd0 : count_q;
  assign rows_loaded = count_q;
  assign sync_err    = sync_err_q;

`ifdef WIN_DBUF_EN

  logic [WIN_W-1:0] bank_a_q, bank_a_d;
  logic [WIN_W-1:0] bank_b_q, bank_b_d;
  logic             fill_sel_q, fill_sel_d;
  logic             pres_sel_q, pres_sel_d;
  logic             pres_valid_q, pres_valid_d;
  logic             complete;
  logic             bank_free;

  // count_q == WIN_DIM means the filling bank is full and waiting for the
  // presented bank to be released, i.e. both banks are occupied.
  assign row_ready = (count_q != FULL_CNT);
  assign win_valid = pres_valid_q;
  assign win_data  = pres_sel_q ? bank_b_q : bank_a_q;
  assign complete  = row_hs & ~restart & (count_q == LAST_ROW);
  assign bank_free = ~pres_valid_q | win_hs;

  // Next-state: write the row into the filling bank and hand the bank over
  // to the presentation side as soon as it is both complete and unblocked.
  always_comb begin
    bank_a_d     = bank_a_q;
    bank_b_d     = bank_b_q;
    fill_sel_d   = fill_sel_q;
    pres_sel_d   = pres_sel_q;
    pres_valid_d = pres_valid_q;
    count_d      = count_q;
    sync_err_d   = 1'b0;
    if (row_hs) begin
      if (fill_sel_q) begin
        bank_b_d[int'(wr_idx)*ROW_W +: ROW_W] = row_data;
      end else begin
        bank_a_d[int'(wr_idx)*ROW_W +: ROW_W] = row_data;
      end
    end
    if (win_hs) begin
      pres_valid_d = 1'b0;
    end
    if (restart) begin
      count_d    = 4'd1;
      sync_err_d = 1'b1;
    end else if (complete) begin
      if (bank_free) begin
        pres_sel_d   = fill_sel_q;
        pres_valid_d = 1'b1;
        fill_sel_d   = ~fill_sel_q;
        count_d      = 4'd0;
      end else begin
        count_d = FULL_CNT;
      end
    end else if (row_hs) begin
      count_d = count_q + 4'd1;
    end else if ((count_q == FULL_CNT) && win_hs) begin
      pres_sel_d   = fill_sel_q;
      pres_valid_d = 1'b1;
      fill_sel_d   = ~fill_sel_q;
      count_d      = 4'd0;
    end
  end

  // Register all bank, pointer and counter state; reset empties both banks.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      bank_a_q     <= '0;
      bank_b_q     <= '0;
      fill_sel_q   <= 1'b0;
      pres_sel_q   <= 1'b0;
      pres_valid_q <= 1'b0;
      count_q      <= 4'd0;
      sync_err_q   <= 1'b0;
    end else begin
      bank_a_q     <= bank_a_d;
      bank_b_q     <= bank_b_d;
      fill_sel_q   <= fill_sel_d;
      pres_sel_q   <= pres_sel_d;
      pres_valid_q <= pres_valid_d;
      count_q      <= count_d;
      sync_err_q   <= sync_err_d;
    end
  end

`else

  typedef enum logic {FILL, FULL} state_t;

  state_t           state_q, state_d;
  logic [WIN_W-1:0] win_q, win_d;

  // Both handshake outputs decode the registered state only, so win_ready
  // never reaches row_ready combinationally.
  assign row_ready = (state_q == FILL);
  assign win_valid = (state_q == FULL);
  assign win_data  = win_q;

  // Next-state: collect rows while filling, hold the window while full.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    win_d      = win_q;
    sync_err_d = 1'b0;
    case (state_q)
      FILL: begin
        if (row_hs) begin
          win_d[int'(wr_idx)*ROW_W +: ROW_W] = row_data;
          if (restart) begin
            count_d    = 4'd1;
            sync_err_d = 1'b1;
          end else if (count_q == LAST_ROW) begin
            count_d = FULL_CNT;
            state_d = FULL;
          end else begin
            count_d = count_q + 4'd1;
          end
        end
      end
      FULL: begin
        if (win_ready) begin
          count_d = 4'd0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Single FSM register block: state, row counter, window and error pulse.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= FILL;
      count_q    <= 4'd0;
      win_q      <= '0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      win_q      <= win_d;
      sync_err_q <= sync_err_d;
    end
  end

`endif

endmodule

// File: tb/tb_ref_window_loader.sv
// Testbench for ref_window_loader. A queue-based model predicts the window
// sequence, handshake levels, rows_loaded and sync_err from the accepted
// rows; directed scenarios add hand-computed literal expectations.
// Build with +define+WIN_DBUF_EN to exercise the ping-pong variant.
module tb_ref_window_loader;

  localparam int PIX_W   = 8;
  localparam int WIN_DIM = 15;
  localparam int ROW_W   = PIX_W * WIN_DIM;
  localparam int WIN_W   = ROW_W * WIN_DIM;
`ifdef WIN_DBUF_EN
  localparam int NBANK = 2;
`else
  localparam int NBANK = 1;
`endif

  logic             clock = 1'b0;
  logic             reset_L = 1'b0;
  logic             row_valid = 1'b0;
  logic             row_sof = 1'b0;
  logic [ROW_W-1:0] row_data = '0;
  logic             row_ready;
  logic             win_valid;
  logic             win_ready = 1'b0;
  logic [WIN_W-1:0] win_data;
  logic [3:0]       rows_loaded;
  logic             sync_err;

  int checks = 0;
  int passes = 0;
  int stallCycles = 0;
  int winCount = 0;
  int winMode = 0;
  bit started = 1'b0;

  logic [ROW_W-1:0] partial[$];
  logic [WIN_W-1:0] expQ[$];
  bit               expSyncErr = 1'b0;
  bit               mRowHs;
  bit               mWinHs;
  logic [WIN_W-1:0] mWin;

  ref_window_loader #(.PIX_W(PIX_W), .WIN_DIM(WIN_DIM)) dut (
    .clock      (clock),
    .reset_L    (reset_L),
    .row_valid  (row_valid),
    .row_sof    (row_sof),
    .row_data   (row_data),
    .row_ready  (row_ready),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_data   (win_data),
    .rows_loaded(rows_loaded),
    .sync_err   (sync_err)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
  endtask

  task automatic checkWindow(input string name, input logic [WIN_W-1:0] actual, input logic [WIN_W-1:0] expected);
    checks++;
    if (actual === expected) passes++;
    else begin
      for (int r = 0; r < WIN_DIM; r++) begin
        if (actual[r*ROW_W +: ROW_W] !== expected[r*ROW_W +: ROW_W]) begin
          $display("[TB] FAIL %s: row %0d got %h expected %h at %0t", name, r,
                   actual[r*ROW_W +: ROW_W], expected[r*ROW_W +: ROW_W], $time);
          break;
        end
      end
    end
  endtask

  function automatic logic [ROW_W-1:0] randRow();
    logic [127:0] t;
    for (int i = 0; i < 4; i++) t[i*32 +: 32] = $urandom;
    return t[ROW_W-1:0];
  endfunction

  function automatic logic [ROW_W-1:0] patRow(input int r);
    logic [ROW_W-1:0] v;
    for (int c = 0; c < WIN_DIM; c++) v[c*PIX_W +: PIX_W] = 8'(r*16 + c);
    return v;
  endfunction

  // Model: rows accepted while fewer than NBANK windows are pending form the
  // next window; a start-of-frame on a non-empty partial discards it.
  always @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      partial.delete();
      expQ.delete();
      expSyncErr = 1'b0;
    end else begin
      mRowHs = row_valid && (expQ.size() < NBANK);
      mWinHs = win_ready && (expQ.size() > 0);
      expSyncErr = 1'b0;
      if (mWinHs) begin
        void'(expQ.pop_front());
        winCount++;
      end
      if (mRowHs) begin
        if (row_sof && partial.size() != 0) begin
          partial.delete();
          expSyncErr = 1'b1;
        end
        partial.push_back(row_data);
        if (partial.size() == WIN_DIM) begin
          for (int r = 0; r < WIN_DIM; r++) mWin[r*ROW_W +: ROW_W] = partial[r];
          expQ.push_back(mWin);
          partial.delete();
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model, away from the edge.
  initial begin
    forever begin
      @(negedge clock);
      if (started && reset_L) begin
        checkOutput("win_valid", 32'(win_valid), 32'(expQ.size() > 0));
        checkOutput("row_ready", 32'(row_ready), 32'(expQ.size() < NBANK));
        checkOutput("rows_loaded", 32'(rows_loaded),
                    (expQ.size() == NBANK) ? 32'(WIN_DIM) : 32'(partial.size()));
        checkOutput("sync_err", 32'(sync_err), 32'(expSyncErr));
        if (expQ.size() > 0) checkWindow("win_data", win_data, expQ[0]);
      end
    end
  end

  // win_ready policy: 0 = always ready, 1 = stalled, 2 = random.
  initial begin
    forever begin
      @(negedge clock);
      case (winMode)
        0:       win_ready = 1'b1;
        1:       win_ready = 1'b0;
        default: win_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Offers one row, holding it until accepted; called just after a negedge.
  task automatic applyStimulus(input logic sof, input logic [ROW_W-1:0] data, input int gap);
    int n;
    for (int g = 0; g < gap; g++) @(negedge clock);
    row_valid = 1'b1;
    row_sof   = sof;
    row_data  = data;
    n = 0;
    while (!row_ready && n < 200) begin
      stallCycles++;
      @(negedge clock);
      n++;
    end
    if (!row_ready) begin
      checks++;
      $display("[TB] FAIL row accept timeout: row_ready 0 for %0d cycles, required 1", n);
    end
    @(negedge clock);
    row_valid = 1'b0;
    row_sof   = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", passes, checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [ROW_W-1:0] rows[WIN_DIM];
    logic [WIN_W-1:0] expWin;
    int base;
    int gap;

    // Reset state
    winMode = 0;
    waitCycles(3);
    checkOutput("reset win_valid", 32'(win_valid), 32'd0);
    checkOutput("reset rows_loaded", 32'(rows_loaded), 32'd0);
    checkOutput("reset sync_err", 32'(sync_err), 32'd0);
    checkWindow("reset win_data", win_data, '0);
    #3 reset_L = 1'b1;
    started = 1'b1;
    @(negedge clock);
    checkOutput("reset row_ready", 32'(row_ready), 32'd1);

    // Test 1: pattern window, always ready
    for (int r = 0; r < WIN_DIM; r++) applyStimulus(r == 0, patRow(r), 0);
    checkOutput("t1 win_valid after row 14", 32'(win_valid), 32'd1);
    for (int r = 0; r < WIN_DIM; r++)
      for (int c = 0; c < WIN_DIM; c++)
        expWin[r*ROW_W + c*PIX_W +: PIX_W] = 8'(r*16 + c);
    checkWindow("t1 pattern bytes", win_data, expWin);
    @(negedge clock);
    checkOutput("t1 win_valid drop", 32'(win_valid), 32'd0);

    // Test 2: window full, interpolator stalled for 20 cycles
    winMode = 1;
    @(negedge clock);
    for (int r = 0; r < WIN_DIM; r++) begin
      rows[r] = randRow();
      applyStimulus(r == 0, rows[r], 0);
      expWin[r*ROW_W +: ROW_W] = rows[r];
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
`ifndef WIN_DBUF_EN
      checkOutput("t2 row_ready stalled", 32'(row_ready), 32'd0);
`endif
    end
    checkOutput("t2 win_valid held", 32'(win_valid), 32'd1);
    checkWindow("t2 win_data held", win_data, expWin);
`ifdef WIN_DBUF_EN
    for (int r = 0; r < WIN_DIM; r++) applyStimulus(r == 0, randRow(), 0);
    checkOutput("t2 dbuf row_ready both full", 32'(row_ready), 32'd0);
    checkOutput("t2 dbuf rows_loaded both full", 32'(rows_loaded), 32'(WIN_DIM));
    checkWindow("t2 dbuf first window still presented", win_data, expWin);
`endif
    winMode = 0;
    waitCycles(5);

    // Test 3: row_sof on the 6th row
    winMode = 1;
    for (int r = 0; r < 5; r++) applyStimulus(r == 0, randRow(), 0);
    rows[0] = randRow();
    applyStimulus(1'b1, rows[0], 0);
    checkOutput("t3 sync_err pulse", 32'(sync_err), 32'd1);
    checkOutput("t3 rows_loaded after sof", 32'(rows_loaded), 32'd1);
    for (int r = 1; r < WIN_DIM; r++) begin
      rows[r] = randRow();
      applyStimulus(1'b0, rows[r], 0);
    end
    for (int r = 0; r < WIN_DIM; r++) expWin[r*ROW_W +: ROW_W] = rows[r];
    checkOutput("t3 win_valid", 32'(win_valid), 32'd1);
    checkWindow("t3 window from sof row", win_data, expWin);
    winMode = 0;
    waitCycles(4);

    // Test 4: reset after 9 rows
    for (int r = 0; r < 9; r++) applyStimulus(r == 0, randRow(), 0);
    #3 reset_L = 1'b0;
    #1;
    checkOutput("t4 win_valid in reset", 32'(win_valid), 32'd0);
    checkOutput("t4 rows_loaded in reset", 32'(rows_loaded), 32'd0);
    @(negedge clock);
    #3 reset_L = 1'b1;
    for (int r = 0; r < WIN_DIM; r++) begin
      rows[r] = randRow();
      applyStimulus(1'b0, rows[r], 0);
      expWin[r*ROW_W +: ROW_W] = rows[r];
    end
    checkOutput("t4 win_valid post reset", 32'(win_valid), 32'd1);
    checkWindow("t4 window post reset only", win_data, expWin);
    waitCycles(3);

    // Test 5: 45 rows back-to-back, always ready
    stallCycles = 0;
    base = winCount;
    for (int r = 0; r < 3*WIN_DIM; r++) applyStimulus((r % WIN_DIM) == 0, randRow(), 0);
    waitCycles(3);
    checkOutput("t5 windows delivered", 32'(winCount - base), 32'd3);
`ifdef WIN_DBUF_EN
    checkOutput("t5 stall cycles", 32'(stallCycles), 32'd0);
`else
    checkOutput("t5 stall cycles", 32'(stallCycles), 32'd2);
`endif

    // Test 6: 50 windows with random stalls and occasional aborted partials
    winMode = 2;
    base = winCount;
    for (int w = 0; w < 50; w++) begin
      if ($urandom_range(0, 4) == 0) begin
        int k;
        k = $urandom_range(1, 5);
        for (int r = 0; r < k; r++) applyStimulus(r == 0, randRow(), 0);
      end
      for (int r = 0; r < WIN_DIM; r++) begin
        gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        applyStimulus(r == 0, randRow(), gap);
      end
    end
    winMode = 0;
    begin
      int n;
      n = 0;
      while (expQ.size() != 0 && n < 100) begin
        @(negedge clock);
        n++;
      end
    end
    waitCycles(2);
    checkOutput("t6 windows delivered", 32'(winCount - base), 32'd50);
    checkOutput("t6 queue drained", 32'(expQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
